// File: rtl/output_drain_pkg.sv
// Shared definitions for the output_drain block.
//   - default geometry of a result tile (element width, rows, columns)
//   - FSM state encoding (FILL=0, DRAIN=1)
//   - idx_bits(): index width helper that never returns 0
package output_drain_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ROWS  = 4;
    localparam int DEF_COLS  = 4;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // A one-entry dimension still needs a 1-bit index.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_drain_ob_row.sv
// ob_row: storage for one captured result row.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset, clears the row to 0
//   i_wr_en    - write the whole row from i_data
//   i_data     - cols*width packed row, column c at [(c+1)*width-1 : c*width]
//   i_col_sel  - column to present on o_data
//   o_data     - selected column element
module ob_row
    import output_drain_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int cols  = DEF_COLS,
    localparam int COL_W = idx_bits(cols)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [cols*width-1:0]   i_data,
    input  logic [COL_W-1:0]        i_col_sel,
    output logic [width-1:0]        o_data
);

    logic [width-1:0] r_col [cols];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < cols; c++) begin
                r_col[c] <= '0;
            end
        end else if (i_wr_en) begin
            for (int c = 0; c < cols; c++) begin
                r_col[c] <= i_data[c*width +: width];
            end
        end
    end

    assign o_data = r_col[i_col_sel];

endmodule

// File: rtl/output_drain.sv
// output_drain: captures a tile of array results row by row, then drains it
// one element per transfer in row-major order over a valid/ready handshake.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   cap_en     - outs_array is valid and is captured as the next row
//   outs_array - cols*width array outputs, column c at [(c+1)*width-1 : c*width]
//   out_ready  - consumer accepts out this cycle
//   out        - current drained element (0 when out_valid=0)
//   out_valid  - out holds a valid element
//   full       - tile complete and draining
//   overflow   - sticky: a capture was dropped while draining
//   wr_row     - next row index to be written
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | accepting rows on cap_en; the final row switches to DRAIN
// DRAIN | presenting element rd_idx; captures are dropped and flag overflow
module output_drain
    import output_drain_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int rows  = DEF_ROWS,
    parameter int cols  = DEF_COLS,
    localparam int ROW_W = idx_bits(rows),
    localparam int COL_W = idx_bits(cols)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_en,
    input  logic [cols*width-1:0]   outs_array,
    input  logic                    out_ready,
    output logic [width-1:0]        out,
    output logic                    out_valid,
    output logic                    full,
    output logic                    overflow,
    output logic [ROW_W-1:0]        wr_row
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(rows - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(cols - 1);

    drain_state_e       r_state;
    drain_state_e       w_state_nxt;
    logic [ROW_W-1:0]   r_wr_row;
    logic [ROW_W-1:0]   w_wr_row_nxt;
    // rd_idx = row*cols + col, kept split so no divider is needed for the read
    logic [ROW_W-1:0]   r_rd_row;
    logic [ROW_W-1:0]   w_rd_row_nxt;
    logic [COL_W-1:0]   r_rd_col;
    logic [COL_W-1:0]   w_rd_col_nxt;
    logic               r_overflow;
    logic               w_overflow_nxt;
    logic               w_cap_we;
    logic [width-1:0]   w_row_out [rows];

    genvar g;
    for (g = 0; g < rows; g++) begin : g_row
        ob_row #(
            .width (width),
            .cols  (cols)
        ) u_row (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_cap_we && (r_wr_row == ROW_W'(g))),
            .i_data    (outs_array),
            .i_col_sel (r_rd_col),
            .o_data    (w_row_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FILL;
            r_wr_row   <= '0;
            r_rd_row   <= '0;
            r_rd_col   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_row   <= w_wr_row_nxt;
            r_rd_row   <= w_rd_row_nxt;
            r_rd_col   <= w_rd_col_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_row_nxt   = r_wr_row;
        w_rd_row_nxt   = r_rd_row;
        w_rd_col_nxt   = r_rd_col;
        w_overflow_nxt = r_overflow;
        w_cap_we       = 1'b0;
        out_valid      = 1'b0;
        full           = 1'b0;
        out            = '0;

        case (r_state)
            FILL: begin
                if (cap_en) begin
                    w_cap_we = 1'b1;
                    if (r_wr_row == LAST_ROW) begin
                        w_wr_row_nxt = '0;
                        w_state_nxt  = DRAIN;
                    end else begin
                        w_wr_row_nxt = r_wr_row + 1'b1;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                full      = 1'b1;
                out       = w_row_out[r_rd_row];
                // Storage is untouched here, including in the last-transfer cycle.
                if (cap_en) begin
                    w_overflow_nxt = 1'b1;
                end
                if (out_ready) begin
                    if (r_rd_col == LAST_COL) begin
                        w_rd_col_nxt = '0;
                        if (r_rd_row == LAST_ROW) begin
                            w_rd_row_nxt = '0;
                            w_state_nxt  = FILL;
                        end else begin
                            w_rd_row_nxt = r_rd_row + 1'b1;
                        end
                    end else begin
                        w_rd_col_nxt = r_rd_col + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    assign overflow = r_overflow;
    assign wr_row   = r_wr_row;

endmodule

// File: tb/tb_output_drain.sv
module tb_output_drain;

    localparam int W = 8;
    localparam int R = 4;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cap_en = 1'b0;
    logic           out_ready = 1'b0;
    logic [C*W-1:0] outs_array = '0;
    logic [W-1:0]   out;
    logic           out_valid;
    logic           full;
    logic           overflow;
    logic [1:0]     wr_row;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] q_exp [$];

    output_drain #(.width(W), .rows(R), .cols(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .outs_array (outs_array),
        .out_ready  (out_ready),
        .out        (out),
        .out_valid  (out_valid),
        .full       (full),
        .overflow   (overflow),
        .wr_row     (wr_row)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Capture one tile starting at base; gap_mode inserts r idle cycles before row r.
    task automatic capture_tile(input logic [W-1:0] base, input int gap_mode);
        logic [C*W-1:0] row;
        logic [W-1:0]   e;
        for (int r = 0; r < R; r++) begin
            if (gap_mode != 0) begin
                for (int k = 0; k < r; k++) begin
                    @(negedge clk);
                    cap_en = 1'b0;
                end
            end
            @(negedge clk);
            checks++;
            if (wr_row !== 2'(r)) begin
                errors++;
                $display("FAIL wr_row_before_capture row=%0d got=%0d exp=%0d", r, wr_row, r);
            end
            for (int c = 0; c < C; c++) begin
                e = base + W'(r * C + c);
                row[c*W +: W] = e;
                q_exp.push_back(e);
            end
            outs_array = row;
            cap_en = 1'b1;
        end
        @(negedge clk);
        cap_en = 1'b0;
    endtask

    // Drain against the scoreboard. ready_mode 0: always ready; 1: 1,0,1,0...
    // inject_cyc: cycle on which cap_en is pulsed with all-ones data.
    task automatic drain_tile(input int ready_mode, input int inject_cyc, input int stop_after,
                              input int max_cyc, output int n_xfer, output int n_cyc);
        n_xfer = 0;
        n_cyc = 0;
        while (q_exp.size() > 0 && n_xfer != stop_after && n_cyc < max_cyc) begin
            out_ready = (ready_mode == 0) ? 1'b1 : ((n_cyc % 2 == 0) ? 1'b1 : 1'b0);
            if (n_cyc == inject_cyc) begin
                cap_en = 1'b1;
                outs_array = '1;
            end else begin
                cap_en = 1'b0;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out !== q_exp[0]) begin
                    errors++;
                    $display("FAIL drain_data xfer=%0d cyc=%0d got=%h exp=%h", n_xfer, n_cyc, out, q_exp[0]);
                end
                if (out_ready) begin
                    void'(q_exp.pop_front());
                    n_xfer++;
                end
            end
            @(negedge clk);
            n_cyc++;
        end
        cap_en = 1'b0;
        out_ready = 1'b0;
        if (q_exp.size() > 0 && n_xfer != stop_after) begin
            errors++;
            $display("FAIL drain_timeout left=%0d after %0d cycles", q_exp.size(), n_cyc);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, full, overflow, wr_row, out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {out_valid, full, overflow, wr_row, out});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, full, overflow, wr_row, out} !== '0) begin
            errors++;
            $display("FAIL post_reset_outputs got=%b exp=0", {out_valid, full, overflow, wr_row, out});
        end
    endtask

    task automatic test_basic();
        int nx, nc;
        capture_tile(8'h01, 0);
        checks++;
        if (out_valid !== 1'b1 || full !== 1'b1 || wr_row !== 2'd0) begin
            errors++;
            $display("FAIL first_valid_latency got valid=%b full=%b wr_row=%0d exp 1 1 0", out_valid, full, wr_row);
        end
        drain_tile(0, -1, -1, 40, nx, nc);
        checks++;
        if (nx !== 16 || nc !== 16) begin
            errors++;
            $display("FAIL basic_xfer_count got xfers=%0d cycles=%0d exp 16 16", nx, nc);
        end
        checks++;
        if (full !== 1'b0 || out_valid !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL basic_after_drain got full=%b valid=%b out=%h exp 0 0 00", full, out_valid, out);
        end
    endtask

    task automatic test_stall();
        int nx, nc;
        capture_tile(8'h01, 0);
        drain_tile(1, -1, -1, 80, nx, nc);
        checks++;
        if (nx !== 16 || nc !== 31) begin
            errors++;
            $display("FAIL stall_xfer_count got xfers=%0d cycles=%0d exp 16 31", nx, nc);
        end
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL stall_after_drain got full=%b exp 0", full);
        end
    endtask

    task automatic test_overflow();
        int nx, nc;
        capture_tile(8'h01, 0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_before got=%b exp=0", overflow);
        end
        drain_tile(0, 3, -1, 40, nx, nc);
        checks++;
        if (overflow !== 1'b1 || wr_row !== 2'd0 || nx !== 16) begin
            errors++;
            $display("FAIL overflow_after got ovf=%b wr_row=%0d xfers=%0d exp 1 0 16", overflow, wr_row, nx);
        end
    endtask

    task automatic test_reset_mid_drain();
        int nx, nc;
        capture_tile(8'h01, 0);
        drain_tile(0, -1, 5, 40, nx, nc);
        checks++;
        if (nx !== 5 || out_valid !== 1'b1 || out !== 8'h06) begin
            errors++;
            $display("FAIL mid_drain_state got xfers=%0d valid=%b out=%h exp 5 1 06", nx, out_valid, out);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, full, overflow, wr_row, out} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got=%b exp=0", {out_valid, full, overflow, wr_row, out});
        end
        q_exp.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        capture_tile(8'hA0, 0);
        drain_tile(0, -1, -1, 40, nx, nc);
        checks++;
        if (nx !== 16 || full !== 1'b0) begin
            errors++;
            $display("FAIL fresh_tile got xfers=%0d full=%b exp 16 0", nx, full);
        end
    endtask

    task automatic test_last_cap();
        int nx, nc;
        capture_tile(8'h41, 0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL last_cap_ovf_before got=%b exp=0", overflow);
        end
        drain_tile(0, 15, -1, 40, nx, nc);
        checks++;
        if (overflow !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || wr_row !== 2'd0 || nx !== 16) begin
            errors++;
            $display("FAIL last_cap_dropped got ovf=%b full=%b valid=%b wr_row=%0d xfers=%0d exp 1 0 0 0 16",
                     overflow, full, out_valid, wr_row, nx);
        end
    endtask

    task automatic test_gaps();
        int nx, nc;
        capture_tile(8'h01, 1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gaps_first_valid got=%b exp=1", out_valid);
        end
        drain_tile(0, -1, -1, 40, nx, nc);
        checks++;
        if (nx !== 16 || nc !== 16 || full !== 1'b0) begin
            errors++;
            $display("FAIL gaps_xfer_count got xfers=%0d cycles=%0d full=%b exp 16 16 0", nx, nc, full);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_reset_mid_drain();
        test_last_cap();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
